// File: rtl/fpdiv_ctrl_if.sv
// Host-side request/response bundle for the Goldschmidt divider sequencer.
// The host drives operands and start; the controller returns busy/done/result.
interface fpdiv_ctrl_if;
  logic        start;
  logic [31:0] in_num;
  logic [31:0] in_denom;
  logic        in_rm;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, in_num, in_denom, in_rm,
                  input  busy, done, result);
  modport slave  (input  start, in_num, in_denom, in_rm,
                  output busy, done, result);
endinterface

// File: rtl/fpdiv_ctrl.sv
// Sequencing controller for the single-precision Goldschmidt divider datapath:
// holds operands, steps enables/selects through IA, refinement, remainder and rounding.
//
// state | meaning
// IDLE  | waiting for start, controls idle
// IA_D  | regb = IA*D, regc = one's complement
// IA_N  | rega = IA*N, iteration counter cleared
// IT_N  | rega = rega*regc
// IT_D  | regb = regb*regc, regc updated, counter increments
// REM   | remainder registers capture
// RND   | dp_ans valid, captured into result at the edge
module fpdiv_ctrl #(
  parameter int ITERS = 3,
  parameter int CNTW  = 3
) (
  input  logic        clk,
  input  logic        reset,
  fpdiv_ctrl_if.slave host,
  input  logic [31:0] dp_ans,
  output logic [31:0] op_num,
  output logic [31:0] op_denom,
  output logic        op_rm,
  output logic        en_a,
  output logic        en_b,
  output logic        en_rem,
  output logic [1:0]  sel_mux3,
  output logic [2:0]  sel_mux5
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IA_D = 3'd1,
    IA_N = 3'd2,
    IT_N = 3'd3,
    IT_D = 3'd4,
    REM  = 3'd5,
    RND  = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic [CNTW-1:0]   cnt, cnt_nxt;
  logic [CNTW-1:0]   cnt_inc;
  logic              accept;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       result_q;

  assign cnt_inc = cnt + CNTW'(1);
  assign accept  = (state == IDLE) && host.start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    en_a      = 1'b0;
    en_b      = 1'b0;
    en_rem    = 1'b0;
    sel_mux3  = 2'd0;
    sel_mux5  = 3'd0;
    case (state)
      IDLE: begin
        if (host.start) state_nxt = IA_D;
      end
      IA_D: begin
        sel_mux5  = 3'd1;
        en_b      = 1'b1;
        state_nxt = IA_N;
      end
      IA_N: begin
        en_a      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = IT_N;
      end
      IT_N: begin
        sel_mux3  = 2'd1;
        sel_mux5  = 3'd2;
        en_a      = 1'b1;
        state_nxt = IT_D;
      end
      // IT_N always runs first so both products of an iteration see the same regc
      IT_D: begin
        sel_mux3  = 2'd1;
        sel_mux5  = 3'd3;
        en_b      = 1'b1;
        cnt_nxt   = cnt_inc;
        state_nxt = (cnt_inc == CNTW'(ITERS)) ? REM : IT_N;
      end
      REM: begin
        sel_mux3  = 2'd2;
        sel_mux5  = 3'd4;
        en_rem    = 1'b1;
        state_nxt = RND;
      end
      RND: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operands change only on an accepting edge, so they are stable while busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_num   <= '0;
      op_denom <= '0;
      op_rm    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= (state == RND);
      if (accept) begin
        op_num   <= host.in_num;
        op_denom <= host.in_denom;
        op_rm    <= host.in_rm;
        busy_q   <= 1'b1;
      end else if (state == RND) begin
        busy_q   <= 1'b0;
      end
      if (state == RND) result_q <= dp_ans;
    end
  end

  assign host.busy   = busy_q;
  assign host.done   = done_q;
  assign host.result = result_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed bench for fpdiv_ctrl; a lookup-table stand-in supplies dp_ans during RND
// based on the held operands, so operand holding and rounding-mode pass-through matter.
module tb_fpdiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  fpdiv_ctrl_if hif ();
  fpdiv_ctrl_if hif1 ();

  logic [31:0] dp_ans, op_num, op_denom;
  logic        op_rm, en_a, en_b, en_rem;
  logic [1:0]  sel_mux3;
  logic [2:0]  sel_mux5;

  logic [31:0] dp_ans1, op_num1, op_denom1;
  logic        op_rm1, en_a1, en_b1, en_rem1;
  logic [1:0]  sel_mux3_1;
  logic [2:0]  sel_mux5_1;

  logic        rnd_ph, rnd_ph1;

  always #5 clk = ~clk;

  fpdiv_ctrl #(.ITERS(3), .CNTW(3)) u_dut (
    .clk(clk), .reset(rst_n), .host(hif), .dp_ans(dp_ans),
    .op_num(op_num), .op_denom(op_denom), .op_rm(op_rm),
    .en_a(en_a), .en_b(en_b), .en_rem(en_rem),
    .sel_mux3(sel_mux3), .sel_mux5(sel_mux5)
  );

  fpdiv_ctrl #(.ITERS(1), .CNTW(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .host(hif1), .dp_ans(dp_ans1),
    .op_num(op_num1), .op_denom(op_denom1), .op_rm(op_rm1),
    .en_a(en_a1), .en_b(en_b1), .en_rem(en_rem1),
    .sel_mux3(sel_mux3_1), .sel_mux5(sel_mux5_1)
  );

  function automatic logic [31:0] dp_model(input logic [31:0] n, input logic [31:0] d,
                                           input logic rm);
    logic [63:0] key;
    key = {n, d};
    case (key)
      {32'h40400000, 32'h3FC00000}: return 32'h40000000;
      {32'h3F800000, 32'h40400000}: return rm ? 32'h3EAAAAAA : 32'h3EAAAAAB;
      {32'h40C00000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h40000000}: return 32'h3F000000;
      default:                      return 32'h7FC00000;
    endcase
  endfunction

  // dp_ans is only meaningful in the cycle after REM; garbage elsewhere
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_ph  <= 1'b0;
      rnd_ph1 <= 1'b0;
    end else begin
      rnd_ph  <= en_rem;
      rnd_ph1 <= en_rem1;
    end
  end

  assign dp_ans  = rnd_ph  ? dp_model(op_num, op_denom, op_rm)    : 32'hDEADBEEF;
  assign dp_ans1 = rnd_ph1 ? dp_model(op_num1, op_denom1, op_rm1) : 32'hDEADBEEF;

  function automatic logic [7:0] ctl(input logic a, input logic b, input logic r,
                                     input logic [1:0] m3, input logic [2:0] m5);
    return {a, b, r, m3, m5};
  endfunction

  logic [7:0] ctl_now;
  assign ctl_now = {en_a, en_b, en_rem, sel_mux3, sel_mux5};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [31:0] n, input logic [31:0] d,
                        input logic rm, input logic [31:0] exp_res);
    int k;
    hif.in_num = n; hif.in_denom = d; hif.in_rm = rm; hif.start = 1'b1;
    tick();
    hif.start = 1'b0;
    k = 0;
    while (!hif.done && k < 40) begin
      tick();
      k++;
    end
    n_tests++;
    if (k !== 10) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, expected 10", name, k);
    end
    n_tests++;
    if (hif.result !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: got %08h, expected %08h", name, hif.result, exp_res);
    end
    tick();
  endtask

  task automatic test_reset();
    hif.start = 1'b0; hif.in_num = '0; hif.in_denom = '0; hif.in_rm = 1'b0;
    hif1.start = 1'b0; hif1.in_num = '0; hif1.in_denom = '0; hif1.in_rm = 1'b0;
    repeat (2) tick();
    n_tests++;
    if ({ctl_now, hif.busy, hif.done} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %03h, expected 000", {ctl_now, hif.busy, hif.done});
    end
    n_tests++;
    if ({op_num, op_denom, op_rm, hif.result} !== 97'd0) begin
      n_fail++;
      $display("FAIL reset_regs: op_num=%08h op_denom=%08h op_rm=%0b result=%08h, expected all 0",
               op_num, op_denom, op_rm, hif.result);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (hif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %0b, expected 0", hif.busy);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] exp_seq [9];
    exp_seq[0] = ctl(0, 1, 0, 2'd0, 3'd1);
    exp_seq[1] = ctl(1, 0, 0, 2'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      exp_seq[2 + 2*i] = ctl(1, 0, 0, 2'd1, 3'd2);
      exp_seq[3 + 2*i] = ctl(0, 1, 0, 2'd1, 3'd3);
    end
    exp_seq[8] = ctl(0, 0, 1, 2'd2, 3'd4);
    hif.in_num = 32'h40400000; hif.in_denom = 32'h3FC00000; hif.in_rm = 1'b0;
    hif.start = 1'b1;
    tick();
    hif.start = 1'b0;
    n_tests++;
    if (hif.busy !== 1'b1 || op_num !== 32'h40400000 || op_denom !== 32'h3FC00000) begin
      n_fail++;
      $display("FAIL seq_accept: busy=%0b op_num=%08h op_denom=%08h, expected 1 40400000 3fc00000",
               hif.busy, op_num, op_denom);
    end
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (ctl_now !== exp_seq[i] || hif.done !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_step%0d: ctl=%02h done=%0b, expected ctl=%02h done=0",
                 i, ctl_now, hif.done, exp_seq[i]);
      end
      tick();
    end
    n_tests++;
    if (ctl_now !== 8'd0 || hif.busy !== 1'b1 || hif.done !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_rnd: ctl=%02h busy=%0b done=%0b, expected 00 1 0", ctl_now, hif.busy, hif.done);
    end
    tick();
    n_tests++;
    if (hif.done !== 1'b1 || hif.busy !== 1'b0 || hif.result !== 32'h40000000) begin
      n_fail++;
      $display("FAIL seq_done: done=%0b busy=%0b result=%08h, expected 1 0 40000000",
               hif.done, hif.busy, hif.result);
    end
    tick();
    n_tests++;
    if (hif.done !== 1'b0 || hif.result !== 32'h40000000) begin
      n_fail++;
      $display("FAIL seq_after: done=%0b result=%08h, expected 0 40000000", hif.done, hif.result);
    end
  endtask

  task automatic test_rounding();
    run_op("third_rne", 32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAB);
    run_op("third_rz",  32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAA);
  endtask

  task automatic test_ignore_start();
    int  dones;
    bit  held_ok;
    dones = 0;
    held_ok = 1'b1;
    hif.in_num = 32'h40C00000; hif.in_denom = 32'h40000000; hif.in_rm = 1'b0;
    hif.start = 1'b1;
    tick();
    for (int c = 0; c < 25; c++) begin
      if (hif.done) dones++;
      if (op_num !== 32'h40C00000) held_ok = 1'b0;
      if (hif.busy) begin
        hif.start  = ~hif.start;
        hif.in_num = $urandom;
      end else begin
        hif.start = 1'b0;
      end
      tick();
    end
    n_tests++;
    if (!held_ok) begin
      n_fail++;
      $display("FAIL ignore_hold: op_num=%08h, expected 40c00000 throughout", op_num);
    end
    n_tests++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL ignore_dones: got %0d done pulses, expected 1", dones);
    end
    n_tests++;
    if (hif.busy !== 1'b0 || hif.result !== 32'h40400000) begin
      n_fail++;
      $display("FAIL ignore_end: busy=%0b result=%08h, expected 0 40400000", hif.busy, hif.result);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, k;
    logic [31:0] r1, r2;
    d1 = -1; d2 = -1; r1 = '0; r2 = '0;
    hif.in_num = 32'h40400000; hif.in_denom = 32'h3FC00000; hif.in_rm = 1'b0;
    hif.start = 1'b1;
    tick();
    hif.in_num = 32'h3F800000; hif.in_denom = 32'h40000000;
    // k counts edges after the first accept
    for (k = 0; k < 30 && d2 < 0; k++) begin
      if (hif.done) begin
        if (d1 < 0) begin d1 = k; r1 = hif.result; end
        else begin d2 = k; r2 = hif.result; hif.start = 1'b0; end
      end
      tick();
    end
    hif.start = 1'b0;
    n_tests++;
    if (d1 !== 10 || r1 !== 32'h40000000) begin
      n_fail++;
      $display("FAIL b2b_first: done at %0d result=%08h, expected 10 40000000", d1, r1);
    end
    // second accept lands on the edge that closes the first done cycle
    n_tests++;
    if (d2 !== 21 || r2 !== 32'h3F000000) begin
      n_fail++;
      $display("FAIL b2b_second: done at %0d result=%08h, expected 21 3f000000", d2, r2);
    end
    repeat (12) tick();
    n_tests++;
    if (hif.busy !== 1'b0 || hif.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%0b done=%0b, expected 0 0", hif.busy, hif.done);
    end
  endtask

  task automatic test_abort_reset();
    hif.in_num = 32'h40C00000; hif.in_denom = 32'h40000000; hif.in_rm = 1'b1;
    hif.start = 1'b1;
    tick();
    hif.start = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (ctl_now !== ctl(1, 0, 0, 2'd1, 3'd2) || hif.result === 32'd0) begin
      n_fail++;
      $display("FAIL abort_pre: ctl=%02h result=%08h, expected ctl=%02h and nonzero result",
               ctl_now, hif.result, ctl(1, 0, 0, 2'd1, 3'd2));
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ctl_now, hif.busy, hif.done} !== 10'd0 ||
        {op_num, op_denom, op_rm, hif.result} !== 97'd0) begin
      n_fail++;
      $display("FAIL abort_async: ctl=%02h busy=%0b done=%0b op_num=%08h op_rm=%0b result=%08h, expected all 0",
               ctl_now, hif.busy, hif.done, op_num, op_rm, hif.result);
    end
    #2 rst_n = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (hif.busy !== 1'b0 || ctl_now !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_release: busy=%0b ctl=%02h, expected 0 00", hif.busy, ctl_now);
    end
  endtask

  task automatic test_iters1();
    int k, rem_k;
    hif1.in_num = 32'h3F800000; hif1.in_denom = 32'h40000000; hif1.in_rm = 1'b0;
    hif1.start = 1'b1;
    tick();
    hif1.start = 1'b0;
    k = 0;
    rem_k = -1;
    while (!hif1.done && k < 30) begin
      if (en_rem1 && rem_k < 0) rem_k = k;
      tick();
      k++;
    end
    n_tests++;
    if (rem_k !== 4) begin
      n_fail++;
      $display("FAIL iters1_rem: REM at %0d, expected 4", rem_k);
    end
    n_tests++;
    if (k !== 6 || hif1.result !== 32'h3F000000) begin
      n_fail++;
      $display("FAIL iters1_done: done at %0d result=%08h, expected 6 3f000000", k, hif1.result);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_rounding();
    test_ignore_start();
    test_back_to_back();
    test_abort_reset();
    test_iters1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
